fetch_unit: RTL and testbench

//   Instruction-fetch stage feeding the controller/datapath of the 32-bit MIPS-style CPU.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem reads and buffers
// returned words, presenting head instruction/op/PC to decode; redirects flush stale work.
module fetch_unit #(
    parameter int             n        = 32,
    parameter logic [n-1:0]   RESET_PC = {n{1'b0}},
    parameter int             DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_valid,
    input  logic [n-1:0] imem_rdata,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [n-1:0] instr,
    output logic [4:0]   op,
    output logic [n-1:0] instr_pc,
    output logic [n-1:0] pcplus4
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [n-1:0]  ZERO_W  = {n{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [n-1:0] pc_inc(input logic [n-1:0] pc);
        return pc + {{(n-3){1'b0}}, 3'b100};
    endfunction

    state_t        state_r, state_next_s;
    logic [n-1:0]  pc_r, pc_next_s;
    logic [n-1:0]  req_pc_r, req_pc_next_s;
    logic [CW-1:0] count_r, count_next_s, wr_idx_s;
    logic          push_s, pop_s, flush_s;
    logic          imem_req_r, instr_valid_r;

    // Shift-register buffer: entry 0 is always the head, vacant entries hold zero
    logic [n-1:0]  data_q_r [DEPTH];
    logic [n-1:0]  pc_q_r   [DEPTH];
    logic [n-1:0]  pcp4_q_r [DEPTH];
    logic [n-1:0]  data_shift_s [DEPTH];
    logic [n-1:0]  pc_shift_s   [DEPTH];
    logic [n-1:0]  pcp4_shift_s [DEPTH];
    logic [n-1:0]  data_next_s  [DEPTH];
    logic [n-1:0]  pc_next_q_s  [DEPTH];
    logic [n-1:0]  pcp4_next_s  [DEPTH];

    // Buffer occupancy bookkeeping
    always_comb begin
        flush_s  = redirect;
        pop_s    = instr_ready && (count_r != ZERO_C);
        push_s   = (state_r == ST_WAIT) && imem_valid && !redirect;
        wr_idx_s = pop_s ? (count_r - ONE_C) : count_r;
        if (flush_s) begin
            count_next_s = ZERO_C;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // Buffer contents: flush, then push into the slot left after any pop, then shift
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            data_shift_s[i] = data_q_r[i+1];
            pc_shift_s[i]   = pc_q_r[i+1];
            pcp4_shift_s[i] = pcp4_q_r[i+1];
        end
        data_shift_s[DEPTH-1] = ZERO_W;
        pc_shift_s[DEPTH-1]   = ZERO_W;
        pcp4_shift_s[DEPTH-1] = ZERO_W;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_s) begin
                data_next_s[i] = ZERO_W;
                pc_next_q_s[i] = ZERO_W;
                pcp4_next_s[i] = ZERO_W;
            end else if (push_s && (CW'(i) == wr_idx_s)) begin
                data_next_s[i] = imem_rdata;
                pc_next_q_s[i] = req_pc_r;
                pcp4_next_s[i] = pc_inc(req_pc_r);
            end else if (pop_s) begin
                data_next_s[i] = data_shift_s[i];
                pc_next_q_s[i] = pc_shift_s[i];
                pcp4_next_s[i] = pcp4_shift_s[i];
            end else begin
                data_next_s[i] = data_q_r[i];
                pc_next_q_s[i] = pc_q_r[i];
                pcp4_next_s[i] = pcp4_q_r[i];
            end
        end
    end

    // Fetch FSM next-state and PC update; redirect outranks everything
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        req_pc_next_s = req_pc_r;
        if (redirect) begin
            pc_next_s = redirect_pc;
            case (state_r)
                ST_IDLE:  state_next_s = ST_REQ;
                // an accepted old-path request still returns data that must be drained
                ST_REQ:   state_next_s = imem_ready ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_next_s = imem_valid ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_next_s = imem_valid ? ST_REQ : ST_DRAIN;
                default:  state_next_s = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = (count_next_s < DEPTH_C) ? ST_REQ : ST_IDLE;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state_next_s  = ST_WAIT;
                        pc_next_s     = pc_inc(pc_r);
                        req_pc_next_s = pc_r;
                    end else begin
                        state_next_s  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        state_next_s = (count_next_s < DEPTH_C) ? ST_REQ : ST_IDLE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_DRAIN: state_next_s = imem_valid ? ST_REQ : ST_DRAIN;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, PC and buffer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            req_pc_r      <= ZERO_W;
            count_r       <= ZERO_C;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q_r[i] <= ZERO_W;
                pc_q_r[i]   <= ZERO_W;
                pcp4_q_r[i] <= ZERO_W;
            end
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            req_pc_r      <= req_pc_next_s;
            count_r       <= count_next_s;
            imem_req_r    <= (state_next_s == ST_REQ);
            instr_valid_r <= (count_next_s != ZERO_C);
            for (int i = 0; i < DEPTH; i++) begin
                data_q_r[i] <= data_next_s[i];
                pc_q_r[i]   <= pc_next_q_s[i];
                pcp4_q_r[i] <= pcp4_next_s[i];
            end
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = data_q_r[0];
    assign op          = data_q_r[0][n-1 -: 5];
    assign instr_pc    = pc_q_r[0];
    assign pcplus4     = pcp4_q_r[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-bench instruction memory (word = 32'h2000_0005 ^ addr)
// with programmable latency, and hand-computed expectations checked cycle by cycle.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] instr_pc;
    logic [31:0] pcplus4;

    int          checks    = 0;
    int          failures  = 0;
    int          mem_lat   = 1;
    int          wait_left = 0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0000_0000;

    always #5 clk = ~clk;

    fetch_unit #(.n(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .instr_pc    (instr_pc),
        .pcplus4     (pcplus4)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h2000_0005 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: note the handshake seen at the edge, then drive memory response
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        hs = imem_req && imem_ready;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = a;
            wait_left = mem_lat;
        end
        imem_valid = 1'b0;
        imem_rdata = 32'h0000_0000;
        if (pend) begin
            wait_left--;
            if (wait_left == 0) begin
                imem_valid = 1'b1;
                imem_rdata = word(pend_addr);
                pend       = 1'b0;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0000_0000;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        instr_ready = 1'b0;
        #2;
        chk1("rst_req",   imem_req,    1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk ("rst_instr", instr,       32'h0000_0000);
        chk ("rst_op",    {27'd0, op}, 32'h0000_0000);
        chk ("rst_pc",    instr_pc,    32'h0000_0000);
        chk ("rst_pcp4",  pcplus4,     32'h0000_0000);
        tick();
        tick();
        reset      = 1'b0;
        imem_ready = 1'b1;

        // Stream from reset, decode stalled
        chk1("a_req", imem_req, 1'b0);
        tick();
        chk1("b_req",   imem_req,    1'b1);
        chk ("b_addr",  imem_addr,   32'h0000_0000);
        chk1("b_valid", instr_valid, 1'b0);
        tick();
        chk1("c_req", imem_req, 1'b0);
        tick();
        chk1("d_valid", instr_valid, 1'b1);
        chk ("d_instr", instr,       32'h2000_0005);
        chk ("d_op",    {27'd0, op}, {27'd0, 5'b00100});
        chk ("d_pc",    instr_pc,    32'h0000_0000);
        chk ("d_pcp4",  pcplus4,     32'h0000_0004);
        chk1("d_req",   imem_req,    1'b1);
        chk ("d_addr",  imem_addr,   32'h0000_0004);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            chk1("hold_req", imem_req, 1'b0);
            chk ("hold_pc",  instr_pc, 32'h0000_0000);
            tick();
        end
        chk1("g_valid", instr_valid, 1'b1);
        chk ("g_instr", instr,       32'h2000_0005);
        instr_ready = 1'b1;
        tick();
        chk ("h_pc",    instr_pc,  32'h0000_0004);
        chk ("h_instr", instr,     32'h2000_0001);
        chk ("h_pcp4",  pcplus4,   32'h0000_0008);
        chk1("h_req",   imem_req,  1'b1);
        chk ("h_addr",  imem_addr, 32'h0000_0008);
        instr_ready = 1'b0;
        mem_lat     = 2;
        tick();

        // Redirect while waiting on slow memory: PC 8 word must be drained
        chk1("i_req", imem_req, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        mem_lat  = 1;
        chk1("j_valid", instr_valid, 1'b0);
        chk1("j_req",   imem_req,    1'b0);
        tick();
        chk1("k_req",   imem_req,    1'b1);
        chk ("k_addr",  imem_addr,   32'h0000_0100);
        chk1("k_valid", instr_valid, 1'b0);
        tick();
        chk1("l_valid", instr_valid, 1'b0);
        tick();
        chk1("m_valid", instr_valid, 1'b1);
        chk ("m_pc",    instr_pc,    32'h0000_0100);
        chk ("m_instr", instr,       32'h2000_0105);
        chk1("m_req",   imem_req,    1'b1);
        chk ("m_addr",  imem_addr,   32'h0000_0104);
        tick();

        // Redirect coinciding with returned data: no drain, 3-cycle latency
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk1("o_req",   imem_req,    1'b1);
        chk ("o_addr",  imem_addr,   32'h0000_0200);
        chk1("o_valid", instr_valid, 1'b0);
        tick();
        chk1("p_valid", instr_valid, 1'b0);
        tick();
        chk1("q_valid", instr_valid, 1'b1);
        chk ("q_pc",    instr_pc,    32'h0000_0200);
        chk ("q_instr", instr,       32'h2000_0205);
        chk ("q_pcp4",  pcplus4,     32'h0000_0204);
        tick();

        // Reset in the middle of a WAIT
        reset      = 1'b1;
        imem_valid = 1'b0;
        pend       = 1'b0;
        #1;
        chk1("r_valid", instr_valid, 1'b0);
        chk ("r_instr", instr,       32'h0000_0000);
        chk ("r_pc",    instr_pc,    32'h0000_0000);
        chk ("r_pcp4",  pcplus4,     32'h0000_0000);
        chk ("r_op",    {27'd0, op}, 32'h0000_0000);
        chk1("r_req",   imem_req,    1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk1("s_req",  imem_req,  1'b1);
        chk ("s_addr", imem_addr, 32'h0000_0000);

        // Redirect to the top word: fetch order wraps to zero
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect    = 1'b0;
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        chk1("t_req",   imem_req,    1'b1);
        chk ("t_addr",  imem_addr,   32'hFFFF_FFFC);
        chk1("t_valid", instr_valid, 1'b0);
        tick();
        tick();
        chk1("v_valid", instr_valid, 1'b1);
        chk ("v_pc",    instr_pc,    32'hFFFF_FFFC);
        chk ("v_instr", instr,       32'hDFFF_FFF9);
        chk ("v_op",    {27'd0, op}, {27'd0, 5'b11011});
        chk ("v_pcp4",  pcplus4,     32'h0000_0000);
        chk1("v_req",   imem_req,    1'b1);
        chk ("v_addr",  imem_addr,   32'h0000_0000);
        tick();
        chk1("w_valid", instr_valid, 1'b0);
        tick();
        chk1("x_valid", instr_valid, 1'b1);
        chk ("x_pc",    instr_pc,    32'h0000_0000);
        chk ("x_instr", instr,       32'h2000_0005);
        chk ("x_pcp4",  pcplus4,     32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
